// File: rtl/apb_intercon_rr.sv
// apb_intercon_rr: N-master to one APB slave bus bridge with
// round-robin grant, base/mask slave decode and unmapped-address error.
module apb_intercon_rr #(
  parameter int BUS_WIDTH    = 16,
  parameter int MASTER_PORTS = 2,
  parameter int SLAVE_PORTS  = 5,
  parameter logic [SLAVE_PORTS*BUS_WIDTH-1:0] SLAVE_BASE = {
    16'h00C0, 16'h00B0, 16'h00A0, 16'h0090, 16'h0080},
  parameter logic [SLAVE_PORTS*BUS_WIDTH-1:0] SLAVE_MASK = {
    16'hFFFF, 16'hFFFE, 16'hFFF0, 16'hFFF0, 16'hFFF0}
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [MASTER_PORTS*BUS_WIDTH-1:0] S_PADDR,
  input  logic [MASTER_PORTS-1:0]        S_PWRITE,
  input  logic [MASTER_PORTS-1:0]        S_PSELx,
  input  logic [MASTER_PORTS-1:0]        S_PENABLE,
  input  logic [MASTER_PORTS*BUS_WIDTH-1:0] S_PWDATA,
  output logic [MASTER_PORTS*BUS_WIDTH-1:0] S_PRDATA,
  output logic [MASTER_PORTS-1:0]        S_PREADY,
  output logic [MASTER_PORTS-1:0]        S_PSLVERR,
  output logic [BUS_WIDTH-1:0]           M_PADDR,
  output logic                           M_PWRITE,
  output logic [SLAVE_PORTS-1:0]         M_PSELx,
  output logic                           M_PENABLE,
  output logic [BUS_WIDTH-1:0]           M_PWDATA,
  input  logic [BUS_WIDTH-1:0]           M_PRDATA,
  input  logic                           M_PREADY
);

  localparam int GW = (MASTER_PORTS > 1) ? $clog2(MASTER_PORTS) : 1;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS
  } state_t;

  state_t          state;
  state_t          state_nx;
  logic [GW-1:0]   g;
  logic [GW-1:0]   g_nx;
  logic [GW-1:0]   lp;
  logic [GW-1:0]   lp_nx;
  logic [GW-1:0]   pick;
  logic            found;
  int              idx;
  logic [BUS_WIDTH-1:0]   sel_addr;
  logic [BUS_WIDTH-1:0]   sel_wdata;
  logic [SLAVE_PORTS-1:0] dec;
  logic            mapped;
  logic            done;
  logic            unused_ok;

  // PENABLE from the masters carries no information the FSM needs
  assign unused_ok = ^S_PENABLE;

  always_comb begin
    pick  = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 1; k <= MASTER_PORTS; k++) begin
      idx = (int'(lp) + k) % MASTER_PORTS;
      if (!found && S_PSELx[idx]) begin
        found = 1'b1;
        pick  = idx[GW-1:0];
      end
    end
  end

  assign sel_addr  = S_PADDR[int'(g)*BUS_WIDTH +: BUS_WIDTH];
  assign sel_wdata = S_PWDATA[int'(g)*BUS_WIDTH +: BUS_WIDTH];

  // scan high to low so the lowest matching window wins
  always_comb begin
    dec = '0;
    for (int i = SLAVE_PORTS - 1; i >= 0; i--) begin
      if ((sel_addr & SLAVE_MASK[i*BUS_WIDTH +: BUS_WIDTH]) ==
          SLAVE_BASE[i*BUS_WIDTH +: BUS_WIDTH]) begin
        dec    = '0;
        dec[i] = 1'b1;
      end
    end
  end

  assign mapped = |dec;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      g     <= '0;
      lp    <= GW'(MASTER_PORTS - 1);
    end else begin
      state <= state_nx;
      g     <= g_nx;
      lp    <= lp_nx;
    end
  end

  always_comb begin
    state_nx = state;
    g_nx     = g;
    lp_nx    = lp;
    done     = 1'b0;
    unique case (state)
      IDLE: begin
        if (|S_PSELx) begin
          g_nx     = pick;
          state_nx = SETUP;
        end
      end
      SETUP: begin
        state_nx = ACCESS;
      end
      ACCESS: begin
        if (!mapped || M_PREADY) begin
          done     = 1'b1;
          lp_nx    = g;
          state_nx = IDLE;
        end
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  always_comb begin
    M_PADDR   = '0;
    M_PWRITE  = 1'b0;
    M_PWDATA  = '0;
    M_PSELx   = '0;
    M_PENABLE = 1'b0;
    S_PREADY  = '0;
    S_PSLVERR = '0;
    S_PRDATA  = '0;
    if (state != IDLE) begin
      M_PADDR   = sel_addr;
      M_PWRITE  = S_PWRITE[g];
      M_PWDATA  = sel_wdata;
      M_PSELx   = dec;
      M_PENABLE = (state == ACCESS);
    end
    if (done) begin
      S_PREADY[g]  = 1'b1;
      S_PSLVERR[g] = !mapped;
      S_PRDATA[int'(g)*BUS_WIDTH +: BUS_WIDTH] =
        mapped ? M_PRDATA : '0;
    end
  end

endmodule

// File: tb/tb_apb_intercon_rr.sv
// tb_apb_intercon_rr: directed plus randomized transfers checked
// against a transaction-level round-robin/decode reference model.
module tb_apb_intercon_rr;

  localparam int BW = 16;
  localparam int NM = 2;
  localparam int NS = 5;

  logic              clk = 1'b0;
  logic              reset;
  logic [NM*BW-1:0]  s_paddr;
  logic [NM-1:0]     s_pwrite;
  logic [NM-1:0]     s_psel;
  logic [NM-1:0]     s_penable;
  logic [NM*BW-1:0]  s_pwdata;
  logic [NM*BW-1:0]  s_prdata;
  logic [NM-1:0]     s_pready;
  logic [NM-1:0]     s_pslverr;
  logic [BW-1:0]     m_paddr;
  logic              m_pwrite;
  logic [NS-1:0]     m_psel;
  logic              m_penable;
  logic [BW-1:0]     m_pwdata;
  logic [BW-1:0]     m_prdata;
  logic              m_pready;

  apb_intercon_rr dut (
    .clk       (clk),
    .reset     (reset),
    .S_PADDR   (s_paddr),
    .S_PWRITE  (s_pwrite),
    .S_PSELx   (s_psel),
    .S_PENABLE (s_penable),
    .S_PWDATA  (s_pwdata),
    .S_PRDATA  (s_prdata),
    .S_PREADY  (s_pready),
    .S_PSLVERR (s_pslverr),
    .M_PADDR   (m_paddr),
    .M_PWRITE  (m_pwrite),
    .M_PSELx   (m_psel),
    .M_PENABLE (m_penable),
    .M_PWDATA  (m_pwdata),
    .M_PRDATA  (m_prdata),
    .M_PREADY  (m_pready)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int errors  = 0;

  int unsigned base_t[NS] = '{16'h0080, 16'h0090, 16'h00A0,
                              16'h00B0, 16'h00C0};
  int unsigned mask_t[NS] = '{16'hFFF0, 16'hFFF0, 16'hFFF0,
                              16'hFFFE, 16'hFFFF};
  int unsigned addr_tab[12] = '{16'h0085, 16'h008F, 16'h0090,
                                16'h009A, 16'h00A3, 16'h00B0,
                                16'h00B1, 16'h00B2, 16'h00C0,
                                16'h00C1, 16'h0040, 16'h1234};

  int unsigned t_addr[NM];
  int unsigned t_data[NM];
  bit          t_wr[NM];
  bit          pend[NM];
  int          lp_m;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int exp_sel(input int unsigned addr);
    for (int i = 0; i < NS; i++)
      if ((addr & mask_t[i]) == base_t[i]) return 1 << i;
    return 0;
  endfunction

  function automatic int next_grant();
    for (int k = 1; k <= NM; k++)
      if (pend[(lp_m + k) % NM]) return (lp_m + k) % NM;
    return -1;
  endfunction

  task automatic set_txn(input int m, input int unsigned a,
                         input bit wr, input int unsigned d);
    pend[m]   = 1'b1;
    t_addr[m] = a & 16'hFFFF;
    t_wr[m]   = wr;
    t_data[m] = d & 16'hFFFF;
  endtask

  task automatic apply();
    for (int m = 0; m < NM; m++) begin
      s_psel[m] = pend[m];
      s_penable[m] = 1'($urandom);
      if (pend[m]) begin
        s_paddr[m*BW +: BW]  = t_addr[m][BW-1:0];
        s_pwdata[m*BW +: BW] = t_data[m][BW-1:0];
        s_pwrite[m]          = t_wr[m];
      end else begin
        s_paddr[m*BW +: BW]  = 16'($urandom);
        s_pwdata[m*BW +: BW] = 16'($urandom);
        s_pwrite[m]          = 1'($urandom);
      end
    end
  endtask

  task automatic idle_checks();
    check("idle_psel", m_psel, 0);
    check("idle_pen", m_penable, 0);
    check("idle_addr", m_paddr, 0);
    check("idle_wdata", m_pwdata, 0);
    check("idle_wr", m_pwrite, 0);
    check("idle_ready", s_pready, 0);
    check("idle_prdata", s_prdata, 0);
  endtask

  // one IDLE cycle, SETUP, then ACCESS with the given wait count
  task automatic run_xfer(input int waits, input bit drop,
                          input logic [BW-1:0] rd);
    int em;
    int sel;
    int w;
    logic [NM*BW-1:0] exp_rd;
    @(negedge clk);
    m_pready = 1'b0;
    apply();
    em = next_grant();
    #1;
    idle_checks();
    if (em < 0) return;
    sel = exp_sel(t_addr[em]);
    w = (sel == 0) ? 0 : waits;
    @(negedge clk);
    #1;
    check("setup_addr", m_paddr, t_addr[em]);
    check("setup_sel", m_psel, sel);
    check("setup_pen", m_penable, 0);
    check("setup_wr", m_pwrite, t_wr[em]);
    check("setup_wdata", m_pwdata, t_data[em]);
    check("setup_ready", s_pready, 0);
    for (int i = 0; i <= w; i++) begin
      @(negedge clk);
      m_prdata = (i == w) ? rd : 16'($urandom);
      m_pready = (sel == 0) ? 1'($urandom) : (i == w);
      if (drop && i == 0) s_psel[em] = 1'b0;
      #1;
      exp_rd = '0;
      if (i == w && sel != 0) exp_rd[em*BW +: BW] = rd;
      check("acc_addr", m_paddr, t_addr[em]);
      check("acc_sel", m_psel, sel);
      check("acc_pen", m_penable, 1);
      check("acc_ready", s_pready, (i == w) ? (1 << em) : 0);
      check("acc_err", s_pslverr,
            (i == w && sel == 0) ? (1 << em) : 0);
      check("acc_rdata", s_prdata, exp_rd);
    end
    pend[em] = 1'b0;
    lp_m = em;
  endtask

  initial begin
    reset = 1'b0;
    s_paddr = '0;
    s_pwdata = '0;
    s_pwrite = '0;
    s_psel = '0;
    s_penable = '0;
    m_prdata = '0;
    m_pready = 1'b0;
    for (int m = 0; m < NM; m++) pend[m] = 1'b0;
    lp_m = NM - 1;
    repeat (3) @(negedge clk);
    #1;
    idle_checks();
    @(negedge clk);
    reset = 1'b1;

    set_txn(0, 16'h0085, 1'b0, 0);
    run_xfer(2, 1'b0, 16'h1234);
    set_txn(1, 16'h00B1, 1'b1, 16'hBEEF);
    run_xfer(0, 1'b0, 16'($urandom));
    set_txn(0, 16'h0040, 1'b0, 0);
    run_xfer(1, 1'b0, 16'hFFFF);
    set_txn(1, 16'h00B2, 1'b1, 16'h5555);
    run_xfer(0, 1'b0, 16'hAAAA);
    set_txn(0, 16'h00C0, 1'b0, 0);
    run_xfer(1, 1'b0, 16'h0C0C);
    set_txn(1, 16'h00C1, 1'b0, 0);
    run_xfer(0, 1'b0, 16'h0C1C);
    set_txn(0, 16'h008F, 1'b1, 16'h1111);
    run_xfer(0, 1'b0, 16'h0000);
    set_txn(1, 16'h0090, 1'b0, 0);
    run_xfer(3, 1'b0, 16'h9090);

    for (int r = 0; r < 6; r++) begin
      for (int m = 0; m < NM; m++)
        if (!pend[m]) set_txn(m, 16'h00A0 + m, 1'b0, 0);
      run_xfer(r % 3, 1'b0, 16'($urandom));
    end

    // reset while the slave is stretching ACCESS
    for (int m = 0; m < NM; m++) pend[m] = 1'b0;
    set_txn(0, 16'h0085, 1'b0, 0);
    @(negedge clk);
    apply();
    @(negedge clk);
    @(negedge clk);
    m_pready = 1'b0;
    #1;
    check("pre_rst_pen", m_penable, 1);
    reset = 1'b0;
    #1;
    check("rst_psel", m_psel, 0);
    check("rst_pen", m_penable, 0);
    check("rst_addr", m_paddr, 0);
    check("rst_ready", s_pready, 0);
    check("rst_err", s_pslverr, 0);
    s_psel = '0;
    pend[0] = 1'b0;
    m_pready = 1'b1;
    @(negedge clk);
    #1;
    check("rst_hold_ready", s_pready, 0);
    m_pready = 1'b0;
    reset = 1'b1;
    lp_m = NM - 1;
    set_txn(0, 16'h0091, 1'b0, 0);
    set_txn(1, 16'h00A1, 1'b1, 16'h7777);
    run_xfer(0, 1'b0, 16'h4242);
    run_xfer(1, 1'b0, 16'h4343);

    for (int r = 0; r < 150; r++) begin
      for (int m = 0; m < NM; m++)
        if (!pend[m] && ($urandom_range(0, 1) == 1))
          set_txn(m, addr_tab[$urandom_range(0, 11)],
                  1'($urandom), $urandom);
      if (!pend[0] && !pend[1])
        set_txn($urandom_range(0, NM - 1), $urandom, 1'($urandom),
                $urandom);
      run_xfer($urandom_range(0, 3), ($urandom_range(0, 3) == 0),
               16'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, errors);
    $finish;
  end

endmodule
